ls_mem_port: RTL and testbench

//  Memory-side responder for the load/store address path. Consumes {valid,addr} words from the

---
 rtl/ls_mem_port.sv | 114 +++++++++++
 tb/tb_ls_mem_port.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ls_mem_port.sv
// ls_mem_port: PE load/store responder with stride-2 vector bursts on a host-shared bank
// Ports: req_addr/req_we/req_vec/req_wdata in, req_ready out; rsp_data/vec_counter/busy out;
// host_en/host_we/host_addr/host_wdata in, host_rdata out; err out only with LS_MEM_RANGE_CHECK_EN
module ls_mem_port #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int VEC_WIDTH_BITS = $clog2(VEC_WIDTH),
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH:0]       req_addr,
  input  logic                      req_we,
  input  logic                      req_vec,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      req_ready,
  output logic [DATA_WIDTH:0]       rsp_data,
  output logic [VEC_WIDTH_BITS-1:0] vec_counter,
  output logic                      busy,
  input  logic                      host_en,
  input  logic                      host_we,
  input  logic [ADDR_BITS-1:0]      host_addr,
  input  logic [DATA_WIDTH-1:0]     host_wdata,
  output logic [DATA_WIDTH-1:0]     host_rdata
`ifdef LS_MEM_RANGE_CHECK_EN
  ,
  output logic                      err
`endif
);
`ifdef LS_MEM_RANGE_CHECK_EN
  // keep full address plus carry so out-of-range elements are detected instead of wrapped
  localparam int EW = DATA_WIDTH + 1;
  logic err_q, err_d;
  assign err = err_q;
`else
  localparam int EW = ADDR_BITS;
`endif
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [VEC_WIDTH_BITS-1:0] cnt_q, cnt_d;
  logic [EW-1:0] base_q, base_d, ea;
  logic we_q, we_d;
  logic [DATA_WIDTH:0] rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0] hrd_q, hrd_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic accept, pe_go, acc_we, oob, mem_we;
  logic [ADDR_BITS-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd, rd;
  assign busy = state_q == BURST;
  assign req_ready = ~busy & ~host_en;
  assign accept = req_addr[DATA_WIDTH] & req_ready;
  assign vec_counter = cnt_q;
  assign rsp_data = rsp_q;
  assign host_rdata = hrd_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      we_q <= 1'b0;
      rsp_q <= '0;
      hrd_q <= '0;
`ifdef LS_MEM_RANGE_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      we_q <= we_d;
      rsp_q <= rsp_d;
      hrd_q <= hrd_d;
`ifdef LS_MEM_RANGE_CHECK_EN
      err_q <= err_d;
`endif
    end
  end
  // a host cycle stalls the burst: counter and state hold
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (busy && !host_en) begin
      state_d = cnt_q == VEC_WIDTH_BITS'(VEC_WIDTH - 1) ? IDLE : BURST;
      cnt_d = state_d == IDLE ? '0 : cnt_q + 1'b1;
    end else if (accept && req_vec) begin
      state_d = BURST;
      cnt_d = VEC_WIDTH_BITS'(1);
    end
  end
  // cnt_q is zero in IDLE, so one adder covers element 0 and the burst elements
  always_comb begin
    pe_go = ~host_en & (busy | accept);
    acc_we = busy ? we_q : req_we;
    ea = (busy ? base_q : EW'(req_addr[DATA_WIDTH-1:0])) + EW'({cnt_q, 1'b0});
`ifdef LS_MEM_RANGE_CHECK_EN
    oob = ea >= EW'(DEPTH);
    err_d = err_q | (pe_go & oob);
`else
    oob = 1'b0;
`endif
    mem_we = host_en ? host_we : pe_go & acc_we & ~oob;
    mem_a = host_en ? host_addr : ea[ADDR_BITS-1:0];
    mem_wd = host_en ? host_wdata : req_wdata;
    rd = mem[mem_a];
    rsp_d = pe_go & ~acc_we ? {1'b1, rd & {DATA_WIDTH{~oob}}} : '0;
    hrd_d = host_en & ~host_we ? rd : hrd_q;
    base_d = accept ? EW'(req_addr[DATA_WIDTH-1:0]) : base_q;
    we_d = accept ? req_we : we_q;
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
  end
endmodule

// File: tb/tb_ls_mem_port.sv
// tb_ls_mem_port: randomized scoreboard bench for ls_mem_port against an array/queue model
module tb_ls_mem_port;
  localparam int DW = 8;
  localparam int VW = 8;
  localparam int DEPTH = 256;
  logic clk = 0;
  logic rst_n = 1;
  logic [DW:0] req_addr = '0;
  logic req_we = 0, req_vec = 0, host_en = 0, host_we = 0;
  logic [DW-1:0] req_wdata = '0, host_wdata = '0;
  logic [7:0] host_addr = '0;
  logic req_ready, busy;
  logic [DW:0] rsp_data;
  logic [2:0] vec_counter;
  logic [DW-1:0] host_rdata;
`ifdef LS_MEM_RANGE_CHECK_EN
  logic err;
`endif
  ls_mem_port dut (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_we(req_we), .req_vec(req_vec),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_data(rsp_data), .vec_counter(vec_counter),
    .busy(busy), .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata)
`ifdef LS_MEM_RANGE_CHECK_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] d; int c;} exp_t;
  exp_t sb[$];
  logic [7:0] ref_mem [DEPTH];
  int nvec = 0, nerr = 0, cyc = 0;
  bit in_burst = 0, bwe = 0, err_exp = 0;
  int ei = 0, bbase = 0;
  logic [7:0] host_last = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rsp_data[DW] === 1'b1) begin
      if (sb.size() == 0) chk("rsp_extra", 32'(rsp_data), 0);
      else begin
        e = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), {23'h0, 1'b1, e.d});
        chk("rsp_cycle", cyc, e.c);
      end
    end else chk("rsp_idle", 32'(rsp_data), 0);
  end
  task automatic elem(input int base, input int i, input bit we, input logic [7:0] wd);
    int ea, a;
    bit oob;
    exp_t e;
    ea = base + 2 * i;
    a = ea % DEPTH;
    oob = 0;
`ifdef LS_MEM_RANGE_CHECK_EN
    oob = ea >= DEPTH;
`endif
    if (oob) err_exp = 1;
    if (!we) begin
      e.d = oob ? 8'h0 : ref_mem[a];
      e.c = cyc + 1;
      sb.push_back(e);
    end else if (!oob) ref_mem[a] = wd;
  endtask
  task automatic step(input bit hen, input bit hwe, input logic [7:0] ha, input logic [7:0] hwd,
                      input bit rv, input bit rwe, input bit rvec, input logic [7:0] ra,
                      input logic [7:0] wd);
    @(posedge clk);
    #1;
    host_en = hen; host_we = hwe; host_addr = ha; host_wdata = hwd;
    req_addr = {rv, ra}; req_we = rwe; req_vec = rvec; req_wdata = wd;
    #1;
    chk("req_ready", 32'(req_ready), 32'(!in_burst && !hen));
    chk("busy", 32'(busy), 32'(in_burst));
    chk("vec_counter", 32'(vec_counter), in_burst ? ei : 0);
    chk("host_rdata", 32'(host_rdata), 32'(host_last));
`ifdef LS_MEM_RANGE_CHECK_EN
    chk("err", 32'(err), 32'(err_exp));
`endif
    if (hen) begin
      if (hwe) ref_mem[ha] = hwd;
      else host_last = ref_mem[ha];
    end else if (in_burst) begin
      elem(bbase, ei, bwe, wd);
      ei++;
      if (ei == VW) in_burst = 0;
    end else if (rv) begin
      elem(ra, 0, rwe, wd);
      if (rvec) begin
        in_burst = 1; ei = 1; bbase = ra; bwe = rwe;
      end
    end
  endtask
  task automatic hwr(input logic [7:0] a, input logic [7:0] d);
    step(1, 1, a, d, 0, 0, 0, 0, 0);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic burst_run(input int stall_pct);
    bit s;
    while (in_burst) begin
      s = $urandom_range(0, 99) < stall_pct;
      step(s, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    sb.delete();
    in_burst = 0; ei = 0; host_last = 0; err_exp = 0;
    host_en = 0; host_we = 0; req_addr = '0; req_we = 0; req_vec = 0;
    #1;
    chk("rst_rsp", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vec_counter", 32'(vec_counter), 0);
    chk("rst_host_rdata", 32'(host_rdata), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  initial begin
    int r;
    #1 do_reset();
    for (int i = 0; i < DEPTH; i++) hwr(8'(i), 8'($urandom));
    hwr(8'h05, 8'h3C);
    step(0, 0, 0, 0, 1, 0, 0, 8'h05, 0);
    step(0, 0, 0, 0, 1, 1, 0, 8'h10, 8'hA5);
    step(0, 0, 0, 0, 1, 0, 0, 8'h10, 0);
    for (int k = 0; k < 8; k++) hwr(8'(2 * k), 8'(k));
    step(0, 0, 0, 0, 1, 0, 1, 8'h00, 0);
    burst_run(0);
    step(0, 0, 0, 0, 1, 0, 1, 8'hFC, 0);
    burst_run(0);
    step(0, 0, 0, 0, 1, 0, 1, 8'h20, 0);
    idle(); idle();
    step(1, 0, 8'h05, 0, 1, 0, 0, 0, 0);
    burst_run(0);
    step(0, 0, 0, 0, 1, 1, 1, 8'h40, 8'h11);
    burst_run(30);
    step(0, 0, 0, 0, 1, 0, 1, 8'h40, 0);
    burst_run(0);
    step(0, 0, 0, 0, 1, 0, 1, 8'h00, 0);
    idle(); idle(); idle();
    do_reset();
    step(0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 1, 0, 0, 8'h06, 0);
    step(0, 0, 0, 0, 1, 0, 0, 8'h10, 0);
    step(0, 0, 0, 0, 1, 0, 0, 8'h05, 0);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) step(1, 1, 8'($urandom), 8'($urandom), 1'($urandom), 0, 0, 8'($urandom), 0);
      else if (r == 2) step(1, 0, 8'($urandom), 0, 1'($urandom), 0, 0, 8'($urandom), 0);
      else if (r < 5) step(0, 0, 0, 0, 1, 1, 0, 8'($urandom), 8'($urandom));
      else if (r < 7) step(0, 0, 0, 0, 1, 0, 0, 8'($urandom), 0);
      else if (r < 9) begin
        step(0, 0, 0, 0, 1, 1'($urandom), 1, 8'($urandom), 8'($urandom));
        burst_run(20);
      end else step(0, 0, 0, 0, 0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    end
    idle(); idle(); idle();
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
